weight_loader: RTL

Streaming weight loader that writes trained weights into per-neuron weight memories at run time, for builds where weights are not preloaded. It accepts a valid/ready word stream (one header word naming the target neuron, then exactly numWeight weight words), decodes the neuron index to a one-hot write enable, and drives the weight memories' write ports (wen/wadd/win) with incrementing addresses. It sits between the host/DMA load path and the layer's bank of weight memories and is the write-side counterpart to the neurons' read sequencing.

---
 rtl/weight_loader_pkg.sv | 18 +
 rtl/weight_wen_decode.sv | 23 ++
 rtl/weight_loader.sv | 111 +++++++++++
 3 files changed

// File: rtl/weight_loader_pkg.sv
// Shared types and header-field constants for the streaming weight loader.
package weight_loader_pkg;

  // Loader FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DROP = 2'd2,
    DONE = 2'd3
  } state_t;

  // Default width of the header neuron-index field
  localparam int unsigned SEL_WIDTH = 5;

  // Bit position of the neuron-index field inside the header word
  localparam int unsigned HDR_IDX_LSB = 0;

endpackage

// File: rtl/weight_wen_decode.sv
// One-hot write-enable decoder; an out-of-range index or a low enable yields all zeros.
module weight_wen_decode
  import weight_loader_pkg::*;
#(
  parameter int unsigned selWidth   = SEL_WIDTH,
  parameter int unsigned numNeurons = 30
) (
  input  logic                  en,
  input  logic [selWidth-1:0]   idx,
  output logic [numNeurons-1:0] onehot
);

  // Index n lights bit n; indices >= numNeurons match no bit
  always_comb begin
    onehot = '0;
    for (int unsigned n = 0; n < numNeurons; n++) begin
      if (en && (idx == selWidth'(n))) begin
        onehot[n] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/weight_loader.sv
// Streaming weight loader: header word selects a neuron, the following
// numWeight words are written into that neuron's weight memory.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int unsigned numWeight    = 784,
  parameter int unsigned numNeurons   = 30,
  parameter int unsigned addressWidth = 10,
  parameter int unsigned dataWidth    = 16,
  parameter int unsigned selWidth     = SEL_WIDTH
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [dataWidth-1:0]    s_data,
  output logic [numNeurons-1:0]   wen,
  output logic [addressWidth-1:0] wadd,
  output logic [dataWidth-1:0]    win,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam logic [addressWidth-1:0] LAST_ADDR  = addressWidth'(numWeight - 1);
  localparam logic [selWidth:0]       NEURON_LIM = (selWidth + 1)'(numNeurons);

  state_t                  state;
  logic [addressWidth-1:0] count;
  logic [selWidth-1:0]     sel;
  logic                    hs;
  logic [selWidth-1:0]     hdr_idx;
  logic                    dec_en;
  logic [numNeurons-1:0]   dec_wen;

  // Handshake and header decode; ready drops only for the single DONE cycle
  assign s_ready = (state != DONE);
  assign busy    = (state != IDLE);
  assign hs      = s_valid && s_ready;
  assign hdr_idx = s_data[HDR_IDX_LSB +: selWidth];
  assign dec_en  = hs && (state == LOAD);

  weight_wen_decode #(
    .selWidth   (selWidth),
    .numNeurons (numNeurons)
  ) u_decode (
    .en     (dec_en),
    .idx    (sel),
    .onehot (dec_wen)
  );

  // FSM, word counter and registered memory write port
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      count <= '0;
      sel   <= '0;
      wen   <= '0;
      wadd  <= '0;
      win   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      wen  <= '0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hs) begin
            count <= '0;
            if ({1'b0, hdr_idx} < NEURON_LIM) begin
              sel   <= hdr_idx;
              state <= LOAD;
            end else begin
              err   <= 1'b1;
              state <= DROP;
            end
          end
        end
        LOAD: begin
          if (hs) begin
            wen  <= dec_wen;
            wadd <= count;
            win  <= s_data;
            if (count == LAST_ADDR) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              count <= count + addressWidth'(1);
            end
          end
        end
        DROP: begin
          if (hs) begin
            if (count == LAST_ADDR) begin
              state <= IDLE;
            end else begin
              count <= count + addressWidth'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
